operand_load_sequencer: RTL and testbench

- Sequences one HalfLoadableRegister-style wide register (e.g. 16-bit MAR/PC) from a narrow memory read port.
- On a start command it issues one or two reads and drives the register's per-half load enables and upper-from-lower select.
- A multi-byte operand therefore lands low byte first, then high byte.
- Sits between the control unit (start/mode/done) and the target register plus the memory read handshake.

---
 rtl/operand_load_sequencer.sv | 132 +++++++++++++
 tb/tb_operand_load_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_load_sequencer.sv
// Loads a wide target register from a narrow memory read port, one or two reads per command.
// Load outputs depend only on state and the latches, so they stay stable for a whole clk_en period.
module operand_load_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic             i_abort,
  output logic             o_rd_req,
  input  logic             i_rd_valid,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic [1:0]       o_load_enable,
  output logic             o_load_upper_from_lower,
  output logic [WIDTH-1:0] o_load_data,
  output logic             o_busy,
  output logic             o_done
);

  localparam int BYTE = WIDTH / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LO,
    S_LOAD_LO,
    S_REQ_HI,
    S_LOAD_HI,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_FULL2 = 2'b00,
    M_LOW1  = 2'b01,
    M_HIGH1 = 2'b10,
    M_WIDE  = 2'b11
  } mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] low_byte_ext;

  assign low_byte_ext = {{(WIDTH - BYTE){1'b0}}, data_q[BYTE-1:0]};

  // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        // DONE accepts a start exactly like IDLE, giving back-to-back sequences.
        if (i_start) begin
          mode_d  = mode_t'(i_mode);
          state_d = (mode_t'(i_mode) == M_HIGH1) ? S_REQ_HI : S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (i_rd_valid) begin
          data_d  = i_rd_data;
          state_d = S_LOAD_LO;
        end
      end
      S_LOAD_LO: begin
        if (i_abort) state_d = S_IDLE;
        else         state_d = (mode_q == M_FULL2) ? S_REQ_HI : S_DONE;
      end
      S_REQ_HI: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (i_rd_valid) begin
          data_d  = i_rd_data;
          state_d = S_LOAD_HI;
        end
      end
      S_LOAD_HI: state_d = i_abort ? S_IDLE : S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_FULL2;
      data_q  <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    o_rd_req                = 1'b0;
    o_load_enable           = 2'b00;
    o_load_upper_from_lower = 1'b0;
    o_load_data             = '0;
    o_busy                  = 1'b0;
    o_done                  = 1'b0;
    unique case (state_q)
      S_REQ_LO, S_REQ_HI: begin
        o_rd_req = 1'b1;
        o_busy   = 1'b1;
      end
      S_LOAD_LO: begin
        o_busy = 1'b1;
        if (mode_q == M_WIDE) begin
          o_load_enable = 2'b11;
          o_load_data   = data_q;
        end else begin
          o_load_enable = 2'b01;
          o_load_data   = low_byte_ext;
        end
      end
      S_LOAD_HI: begin
        o_busy                  = 1'b1;
        o_load_enable           = 2'b10;
        o_load_upper_from_lower = 1'b1;
        o_load_data             = low_byte_ext;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_operand_load_sequencer.sv
// Directed bench for operand_load_sequencer: a model target register, a read responder with
// programmable latency, a vector table of single sequences and hand-built multi-cycle corner cases.
module tb_operand_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        i_start;
  logic [1:0]  i_mode;
  logic        i_abort;
  logic        o_rd_req;
  logic        i_rd_valid;
  logic [15:0] i_rd_data;
  logic [1:0]  o_load_enable;
  logic        o_load_upper_from_lower;
  logic [15:0] o_load_data;
  logic        o_busy;
  logic        o_done;

  operand_load_sequencer #(.WIDTH(16)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .clk_en                  (clk_en),
    .i_start                 (i_start),
    .i_mode                  (i_mode),
    .i_abort                 (i_abort),
    .o_rd_req                (o_rd_req),
    .i_rd_valid              (i_rd_valid),
    .i_rd_data               (i_rd_data),
    .o_load_enable           (o_load_enable),
    .o_load_upper_from_lower (o_load_upper_from_lower),
    .o_load_data             (o_load_data),
    .o_busy                  (o_busy),
    .o_done                  (o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // clk_en generator: every cycle, or one cycle in three
  bit pulse_mode = 1'b0;
  int en_phase   = 0;
  always @(negedge clk) begin
    en_phase <= (en_phase == 2) ? 0 : en_phase + 1;
    clk_en   <= !pulse_mode || (en_phase == 2);
  end

  // Target register model and event counters (all cumulative)
  logic [15:0] tgt = 16'h0000;
  logic [15:0] pre_val = 16'h0000;
  bit          do_preload = 1'b0;
  logic [15:0] ld_first = 16'h0000;
  int ld_mark = 0, load_clks = 0, load_edges = 0, ufl_edges = 0, req_clks = 0;
  int done_edges = 0, en_edges = 0, rd_idx = 0, wait_cnt = 0;

  always @(posedge clk) begin
    if (do_preload) begin
      tgt <= pre_val;
    end else if (clk_en) begin
      if (o_load_enable[0]) tgt[7:0] <= o_load_data[7:0];
      if (o_load_enable[1]) tgt[15:8] <= o_load_upper_from_lower ? o_load_data[7:0] : o_load_data[15:8];
    end
    if (o_load_enable != 2'b00) load_clks <= load_clks + 1;
    if (clk_en && o_load_enable != 2'b00) begin
      load_edges <= load_edges + 1;
      if (load_edges == ld_mark) ld_first <= o_load_data;
    end
    if (clk_en && o_load_enable == 2'b10 && o_load_upper_from_lower) ufl_edges <= ufl_edges + 1;
    if (o_rd_req) req_clks <= req_clks + 1;
    if (clk_en && o_done) done_edges <= done_edges + 1;
    if (clk_en) en_edges <= en_edges + 1;
    if (rst) begin
      wait_cnt <= 0;
    end else if (clk_en && o_rd_req) begin
      if (i_rd_valid) begin
        rd_idx   <= rd_idx + 1;
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Read responder: data valid after rd_delay clk_en periods of request
  logic [15:0] rd_d0 = 16'h0, rd_d1 = 16'h0;
  int rd_delay = 0, rd_base = 0;
  always @(negedge clk) begin
    i_rd_valid <= o_rd_req && (wait_cnt >= rd_delay);
    i_rd_data  <= (rd_idx == rd_base) ? rd_d0 : rd_d1;
  end

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] pre;
    logic [15:0] exp_reg;
    logic [15:0] exp_ld;
    int          exp_lat;
    int          exp_loads;
    int          exp_ufl;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic en_edge();
    do @(posedge clk); while (!clk_en);
    #1;
  endtask

  task automatic preload(input logic [15:0] v);
    @(negedge clk);
    pre_val    = v;
    do_preload = 1'b1;
    @(posedge clk);
    #1;
    do_preload = 1'b0;
  endtask

  task automatic arm_reads(input logic [15:0] d0, input logic [15:0] d1, input int delay);
    rd_d0    = d0;
    rd_d1    = d1;
    rd_delay = delay;
    rd_base  = rd_idx;
    ld_mark  = load_edges;
  endtask

  task automatic wait_done(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      en_edge();
      if (o_done) got = 1'b1;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int delay, input bit poke);
    int s_edge, s_lclk, s_ledge, s_ufl, s_req, s_done, p, nreads;
    bit got;
    p      = pulse_mode ? 3 : 1;
    nreads = (v.mode == 2'b00) ? 2 : 1;
    preload(v.pre);
    arm_reads(v.d0, v.d1, delay);
    s_lclk = load_clks; s_ledge = load_edges; s_ufl = ufl_edges; s_req = req_clks; s_done = done_edges;
    @(negedge clk);
    i_mode  = v.mode;
    i_start = 1'b1;
    en_edge();
    s_edge = en_edges;
    check({tag, " busy_after_start"}, o_busy, 1'b1);
    @(negedge clk);
    i_start = 1'b0;
    if (poke) begin
      i_mode  = 2'b10;
      i_start = 1'b1;
      en_edge();
      en_edge();
      @(negedge clk);
      i_start = 1'b0;
    end
    wait_done(400, got);
    check({tag, " done_seen"}, got, 1'b1);
    check({tag, " latency"}, en_edges - s_edge, v.exp_lat + nreads * delay);
    check({tag, " reg"}, tgt, v.exp_reg);
    check({tag, " first_load_data"}, ld_first, v.exp_ld);
    check({tag, " load_edges"}, load_edges - s_ledge, v.exp_loads);
    check({tag, " load_clks"}, load_clks - s_lclk, p * v.exp_loads);
    check({tag, " hi_ufl_edges"}, ufl_edges - s_ufl, v.exp_ufl);
    check({tag, " req_clks"}, req_clks - s_req, p * nreads * (delay + 1));
    en_edge();
    check({tag, " done_one_period"}, {o_done, o_busy}, 2'b00);
    check({tag, " done_count"}, done_edges - s_done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    int s_ledge, s_done;
    //            mode   d0        d1        pre       exp_reg   exp_ld   lat ld ufl
    vecs[0] = '{2'b00, 16'h0034, 16'h0012, 16'h0000, 16'h1234, 16'h0034, 4, 2, 1};
    vecs[1] = '{2'b01, 16'h0055, 16'h0000, 16'hAA00, 16'hAA55, 16'h0055, 2, 1, 0};
    vecs[2] = '{2'b11, 16'hBEEF, 16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF, 2, 1, 0};
    vecs[3] = '{2'b10, 16'h007A, 16'h0000, 16'h00CD, 16'h7ACD, 16'h007A, 2, 1, 1};
    vecs[4] = '{2'b00, 16'hFF34, 16'hEE12, 16'h5678, 16'h1234, 16'h0034, 4, 2, 1};
    vecs[5] = '{2'b01, 16'h99C3, 16'h0000, 16'h1111, 16'h11C3, 16'h00C3, 2, 1, 0};
    vecs[6] = '{2'b10, 16'h3C5A, 16'h0000, 16'h00FF, 16'h5AFF, 16'h005A, 2, 1, 1};
    vecs[7] = '{2'b11, 16'h0001, 16'h0000, 16'hFFFF, 16'h0001, 16'h0001, 2, 1, 0};

    rst = 1'b1; i_start = 1'b0; i_mode = 2'b00; i_abort = 1'b0;
    #1;
    check("reset_outputs", {o_rd_req, o_load_enable, o_load_upper_from_lower, o_load_data, o_busy, o_done}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    en_edge();
    check("idle_after_reset", {o_rd_req, o_load_enable, o_busy, o_done}, '0);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i], 0, 1'b0);
    run_vec("full2_delay3", vecs[0], 3, 1'b0);

    // clk_en one in three, each read answered after 5 clk_en periods
    pulse_mode = 1'b1;
    run_vec("pulse_full2", vecs[0], 5, 1'b0);
    pulse_mode = 1'b0;
    repeat (4) @(posedge clk);

    // start while busy must be ignored
    run_vec("busy_start", vecs[0], 2, 1'b1);

    // abort in REQ_HI on the same edge the read completes
    preload(16'h0000);
    arm_reads(16'h0034, 16'h0012, 0);
    s_ledge = load_edges; s_done = done_edges;
    @(negedge clk); i_mode = 2'b00; i_start = 1'b1;
    en_edge();
    @(negedge clk); i_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      en_edge();
      if (o_rd_req && rd_idx != rd_base) got = 1'b1;
    end
    check("abort reached_req_hi", got, 1'b1);
    @(negedge clk); i_abort = 1'b1;
    en_edge();
    check("abort state_idle", {o_rd_req, o_load_enable, o_busy, o_done}, '0);
    @(negedge clk); i_abort = 1'b0;
    repeat (6) en_edge();
    check("abort no_done", done_edges - s_done, 0);
    check("abort loads", load_edges - s_ledge, 1);
    check("abort reg", tgt, 16'h0034);

    // start in DONE launches the next sequence on the following edge
    preload(16'h0000);
    arm_reads(16'h0055, 16'hBEEF, 0);
    s_done = done_edges;
    @(negedge clk); i_mode = 2'b01; i_start = 1'b1;
    en_edge();
    @(negedge clk); i_start = 1'b0;
    wait_done(50, got);
    check("b2b first_done", got, 1'b1);
    check("b2b first_reg", tgt, 16'h0055);
    @(negedge clk); i_mode = 2'b11; i_start = 1'b1;
    en_edge();
    check("b2b immediate_req", {o_rd_req, o_busy, o_done}, 3'b110);
    @(negedge clk); i_start = 1'b0;
    wait_done(50, got);
    check("b2b second_done", got, 1'b1);
    check("b2b second_reg", tgt, 16'hBEEF);
    en_edge();
    check("b2b done_count", done_edges - s_done, 2);

    // asynchronous reset while waiting in REQ_HI
    preload(16'h0000);
    arm_reads(16'h0034, 16'h0012, 3);
    s_ledge = load_edges;
    @(negedge clk); i_mode = 2'b00; i_start = 1'b1;
    en_edge();
    @(negedge clk); i_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      en_edge();
      if (o_rd_req && rd_idx != rd_base) got = 1'b1;
    end
    check("rst reached_req_hi", got, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst outputs_immediate", {o_rd_req, o_load_enable, o_load_upper_from_lower, o_load_data, o_busy, o_done}, '0);
    @(negedge clk); rst = 1'b0;
    repeat (8) en_edge();
    check("rst no_more_loads", load_edges - s_ledge, 1);
    check("rst half_loaded_reg", tgt, 16'h0034);
    check("rst idle", {o_rd_req, o_busy, o_done}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
